id_redirect_ctrl: RTL and testbench

Decode-stage control that consumes the IF/ID register outputs (`IFIDOUTPC`, `IFIDOUTInst`) and drives back the fetch-side controls `PCsel`, `JumporBranch` and `CNTEN`. It does the following:
- resolves BEQ/BNE/J/JAL/JR in ID;
- detects load-use and branch-operand hazards through a two-deep destination history, stalling fetch and inserting ID/EX bubbles;
- squashes the one mis-paired IF/ID word that follows every redirect.

---
 rtl/id_redirect_ctrl_pkg.sv | 31 +++
 rtl/id_redirect_ctrl_if.sv | 23 ++
 rtl/id_redirect_ctrl_hazard_hist.sv | 44 ++++
 rtl/id_redirect_ctrl.sv | 142 ++++++++++++++
 tb/tb_id_redirect_ctrl.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/id_redirect_ctrl_pkg.sv
// Shared decode constants, FSM state and history-entry type for the ID-stage
// redirect/hazard controller.
package id_redirect_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic [4:0] dst;
        logic       is_load;
    } hist_t;

    localparam hist_t HIST_NULL = '{dst: 5'd0, is_load: 1'b0};

    // A source hits an entry only if it is really read and the entry really writes.
    function automatic logic src_hit(logic [4:0] src, logic used, hist_t h);
        return used && (h.dst != 5'd0) && (src == h.dst);
    endfunction

endpackage

// File: rtl/id_redirect_ctrl_if.sv
// IF/ID-side bundle: the decoded word and operands in, fetch redirect/stall controls out.
interface id_redirect_ctrl_if;

    logic [31:0] IFIDPC;
    logic [31:0] IFIDInst;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic        PCsel;
    logic [31:0] JumporBranch;
    logic        CNTEN;
    logic        IDEXBubble;

    modport master (
        output IFIDPC, IFIDInst, RsData, RtData,
        input  PCsel, JumporBranch, CNTEN, IDEXBubble
    );

    modport slave (
        input  IFIDPC, IFIDInst, RsData, RtData,
        output PCsel, JumporBranch, CNTEN, IDEXBubble
    );

endinterface

// File: rtl/id_redirect_ctrl_hazard_hist.sv
// Two-deep destination history of issued instructions and the resulting
// load-use / branch-operand stall request for the word currently in ID.
module id_hazard_hist
    import id_redirect_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RSTB,
    input  hist_t      cur_wr,
    input  logic       bubble,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       rs_used,
    input  logic       rt_used,
    input  logic       is_ctrl,
    output logic       stall
);

    hist_t h1_reg;
    hist_t h2_reg;
    logic  hit1;
    logic  hit2;

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            h1_reg <= HIST_NULL;
            h2_reg <= HIST_NULL;
        end else begin
            h2_reg <= h1_reg;
            h1_reg <= bubble ? HIST_NULL : cur_wr;
        end
    end

    always_comb begin
        hit1 = src_hit(rs, rs_used, h1_reg) || src_hit(rt, rt_used, h1_reg);
        hit2 = src_hit(rs, rs_used, h2_reg) || src_hit(rt, rt_used, h2_reg);
        // Branches resolve in ID, so they must wait for any writer one ahead
        // and for a load two ahead; ordinary ops only wait on a load one ahead.
        if (is_ctrl)
            stall = hit1 || (hit2 && h2_reg.is_load);
        else
            stall = hit1 && h1_reg.is_load;
    end

endmodule

// File: rtl/id_redirect_ctrl.sv
// ID-stage control: resolves BEQ/BNE/J/JAL/JR, stalls on hazards and squashes
// the mis-paired IF/ID word that follows every redirect.
module id_redirect_ctrl
    import id_redirect_ctrl_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RSTB,
    id_redirect_ctrl_if.slave    bus
);

    state_t      state_reg;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        rs_used;
    logic        rt_used;
    logic        is_br;
    logic        is_jump;
    logic        is_jr;
    logic        is_ctrl;
    hist_t       cur_wr;
    logic        taken;
    logic        stall_raw;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] target;
    logic        pcsel_next;
    logic [31:0] jb_next;
    logic        cnten_next;
    logic        bubble_next;

    assign opcode = bus.IFIDInst[31:26];
    assign funct  = bus.IFIDInst[5:0];
    assign rs     = bus.IFIDInst[25:21];
    assign rt     = bus.IFIDInst[20:16];
    assign rd     = bus.IFIDInst[15:11];

    always_comb begin
        rs_used = 1'b0;
        rt_used = 1'b0;
        is_br   = 1'b0;
        is_jump = 1'b0;
        is_jr   = 1'b0;
        cur_wr  = HIST_NULL;
        case (opcode)
            OP_RTYPE: begin
                rs_used = 1'b1;
                if (funct == FN_JR) begin
                    is_jr = 1'b1;
                end else begin
                    rt_used    = 1'b1;
                    cur_wr.dst = rd;
                end
            end
            OP_J:   is_jump = 1'b1;
            OP_JAL: begin
                is_jump    = 1'b1;
                cur_wr.dst = 5'd31;
            end
            OP_BEQ, OP_BNE: begin
                rs_used = 1'b1;
                rt_used = 1'b1;
                is_br   = 1'b1;
            end
            OP_LW: begin
                rs_used        = 1'b1;
                cur_wr.dst     = rt;
                cur_wr.is_load = 1'b1;
            end
            OP_SW: begin
                rs_used = 1'b1;
                rt_used = 1'b1;
            end
            default: begin
                // 0x08..0x0F immediate ALU ops
                if (opcode[5:3] == 3'b001) begin
                    rs_used    = 1'b1;
                    cur_wr.dst = rt;
                end
            end
        endcase
    end

    assign is_ctrl   = is_br || is_jr;
    assign br_target = bus.IFIDPC + {{14{bus.IFIDInst[15]}}, bus.IFIDInst[15:0], 2'b00};
    assign j_target  = {bus.IFIDPC[31:28], bus.IFIDInst[25:0], 2'b00};
    assign target    = is_br ? br_target : (is_jr ? bus.RsData : j_target);
    assign taken     = is_jump || is_jr ||
                       (is_br && ((opcode == OP_BEQ) == (bus.RsData == bus.RtData)));

    id_hazard_hist u_hist (
        .CLK     (CLK),
        .RSTB    (RSTB),
        .cur_wr  (cur_wr),
        .bubble  (bubble_next),
        .rs      (rs),
        .rt      (rt),
        .rs_used (rs_used),
        .rt_used (rt_used),
        .is_ctrl (is_ctrl),
        .stall   (stall_raw)
    );

    // Reset and FLUSH both present a squash; only RUN evaluates hazards/redirects.
    always_comb begin
        pcsel_next  = 1'b0;
        jb_next     = 32'd0;
        cnten_next  = 1'b1;
        bubble_next = 1'b1;
        if (RSTB && (state_reg == RUN)) begin
            if (stall_raw) begin
                cnten_next = 1'b0;
            end else begin
                bubble_next = 1'b0;
                if (taken) begin
                    pcsel_next = 1'b1;
                    jb_next    = target;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            state_reg <= FLUSH;
        end else begin
            case (state_reg)
                RUN:     if (!stall_raw && taken) state_reg <= FLUSH;
                FLUSH:   state_reg <= RUN;
                default: state_reg <= FLUSH;
            endcase
        end
    end

    assign bus.PCsel        = pcsel_next;
    assign bus.JumporBranch = jb_next;
    assign bus.CNTEN        = cnten_next;
    assign bus.IDEXBubble   = bubble_next;

endmodule

// File: tb/tb_id_redirect_ctrl.sv
// Directed-vector bench for id_redirect_ctrl with hand-computed expectations.
module tb_id_redirect_ctrl;

    logic CLK;
    logic RSTB;
    int   n_vec;
    int   n_bad;

    id_redirect_ctrl_if bus ();

    id_redirect_ctrl dut (
        .CLK  (CLK),
        .RSTB (RSTB),
        .bus  (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic pcsel, input logic [31:0] jb,
                              input logic cnten, input logic bub);
        chk({tag, ".PCsel"},        {31'd0, bus.PCsel},      {31'd0, pcsel});
        chk({tag, ".JumporBranch"}, bus.JumporBranch,        jb);
        chk({tag, ".CNTEN"},        {31'd0, bus.CNTEN},      {31'd0, cnten});
        chk({tag, ".IDEXBubble"},   {31'd0, bus.IDEXBubble}, {31'd0, bub});
        $display("vec %-14s pc=%08h inst=%08h -> PCsel=%0b JB=%08h CNTEN=%0b BUB=%0b",
                 tag, bus.IFIDPC, bus.IFIDInst, bus.PCsel, bus.JumporBranch, bus.CNTEN, bus.IDEXBubble);
    endtask

    // One ID cycle: present the word just after the edge, sample at the falling edge.
    task automatic apply(input logic rstb, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] rsd, input logic [31:0] rtd);
        @(posedge CLK);
        #1;
        RSTB         = rstb;
        bus.IFIDPC   = pc;
        bus.IFIDInst = inst;
        bus.RsData   = rsd;
        bus.RtData   = rtd;
        @(negedge CLK);
    endtask

    logic [31:0] lw8, add9, beq8, addi3, bne34, jr31;

    initial begin
        n_vec = 0;
        n_bad = 0;
        lw8   = enc_i(6'h23, 5'd2, 5'd8, 16'h0000);
        add9  = enc_r(5'd8, 5'd1, 5'd9, 6'h20);
        beq8  = enc_i(6'h04, 5'd8, 5'd0, 16'hFFFF);
        addi3 = enc_i(6'h08, 5'd0, 5'd3, 16'h0001);
        bne34 = enc_i(6'h05, 5'd3, 5'd4, 16'h0010);
        jr31  = enc_r(5'd31, 5'd0, 5'd0, 6'h08);

        RSTB         = 1'b0;
        bus.IFIDPC   = 32'h0;
        bus.IFIDInst = 32'h0;
        bus.RsData   = 32'h0;
        bus.RtData   = 32'h0;

        // Reset held two cycles with a taken-looking jump present
        apply(1'b0, 32'h00000010, {6'h02, 26'h0000040}, 32'h0, 32'h0);
        expect_out("rst0", 1'b0, 32'h0, 1'b1, 1'b1);
        apply(1'b0, 32'h00000010, {6'h02, 26'h0000040}, 32'h0, 32'h0);
        expect_out("rst1", 1'b0, 32'h0, 1'b1, 1'b1);
        apply(1'b1, 32'h00000010, {6'h02, 26'h0000040}, 32'h0, 32'h0);
        expect_out("rel_flush", 1'b0, 32'h0, 1'b1, 1'b1);

        // Load-use: one stall, then ADD issues
        apply(1'b1, 32'h00000004, lw8, 32'h0, 32'h0);
        expect_out("lw8", 1'b0, 32'h0, 1'b1, 1'b0);
        apply(1'b1, 32'h00000008, add9, 32'h0, 32'h0);
        expect_out("add_stall", 1'b0, 32'h0, 1'b0, 1'b1);
        apply(1'b1, 32'h00000008, add9, 32'h0, 32'h0);
        expect_out("add_issue", 1'b0, 32'h0, 1'b1, 1'b0);

        // Branch behind a load: two stalls, then taken to 0x100
        apply(1'b1, 32'h00000100, lw8, 32'h0, 32'h0);
        expect_out("lw8b", 1'b0, 32'h0, 1'b1, 1'b0);
        apply(1'b1, 32'h00000104, beq8, 32'd5, 32'd5);
        expect_out("beq_stall1", 1'b0, 32'h0, 1'b0, 1'b1);
        apply(1'b1, 32'h00000104, beq8, 32'd5, 32'd5);
        expect_out("beq_stall2", 1'b0, 32'h0, 1'b0, 1'b1);
        apply(1'b1, 32'h00000104, beq8, 32'd5, 32'd5);
        expect_out("beq_taken", 1'b1, 32'h00000100, 1'b1, 1'b0);
        apply(1'b1, 32'h00000104, add9, 32'd0, 32'd0);
        expect_out("beq_flush", 1'b0, 32'h0, 1'b1, 1'b1);

        // ALU writer then BNE: one stall, taken, FLUSH ignores a jump word
        apply(1'b1, 32'h000001FC, addi3, 32'h0, 32'h0);
        expect_out("addi3", 1'b0, 32'h0, 1'b1, 1'b0);
        apply(1'b1, 32'h00000200, bne34, 32'd1, 32'd2);
        expect_out("bne_stall", 1'b0, 32'h0, 1'b0, 1'b1);
        apply(1'b1, 32'h00000200, bne34, 32'd1, 32'd2);
        expect_out("bne_taken", 1'b1, 32'h00000240, 1'b1, 1'b0);
        apply(1'b1, 32'h00000204, {6'h02, 26'h0001234}, 32'd0, 32'd0);
        expect_out("bne_flush", 1'b0, 32'h0, 1'b1, 1'b1);

        // BNE with equal operands falls through
        apply(1'b1, 32'h00000244, bne34, 32'd7, 32'd7);
        expect_out("bne_nt", 1'b0, 32'h0, 1'b1, 1'b0);

        // J keeps PC[31:28]
        apply(1'b1, 32'h80000010, {6'h02, 26'h0000040}, 32'h0, 32'h0);
        expect_out("j", 1'b1, 32'h80000100, 1'b1, 1'b0);
        apply(1'b1, 32'h80000014, 32'h0, 32'h0, 32'h0);
        expect_out("j_flush", 1'b0, 32'h0, 1'b1, 1'b1);

        // JAL, then a JR $31 sitting in FLUSH must be ignored
        apply(1'b1, 32'h00000010, {6'h03, 26'h0000100}, 32'h0, 32'h0);
        expect_out("jal", 1'b1, 32'h00000400, 1'b1, 1'b0);
        apply(1'b1, 32'h00000014, jr31, 32'h00400020, 32'h0);
        expect_out("jal_flush", 1'b0, 32'h0, 1'b1, 1'b1);

        // JR $31: JAL is two back and not a load, so no stall
        apply(1'b1, 32'h00000404, jr31, 32'h00400020, 32'h0);
        expect_out("jr", 1'b1, 32'h00400020, 1'b1, 1'b0);
        apply(1'b1, 32'h00000408, 32'h0, 32'h0, 32'h0);
        expect_out("jr_flush", 1'b0, 32'h0, 1'b1, 1'b1);

        // Reset asserted during a stall overrides it and reloads FLUSH
        apply(1'b1, 32'h00400024, lw8, 32'h0, 32'h0);
        expect_out("lw8c", 1'b0, 32'h0, 1'b1, 1'b0);
        apply(1'b1, 32'h00400028, add9, 32'h0, 32'h0);
        expect_out("stall_pre", 1'b0, 32'h0, 1'b0, 1'b1);
        RSTB = 1'b0;
        #1;
        expect_out("stall_rst", 1'b0, 32'h0, 1'b1, 1'b1);
        apply(1'b1, 32'h00400028, add9, 32'h0, 32'h0);
        expect_out("rst_flush", 1'b0, 32'h0, 1'b1, 1'b1);
        apply(1'b1, 32'h00400028, add9, 32'h0, 32'h0);
        expect_out("post_rst", 1'b0, 32'h0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
